// File: rtl/mipi_lane_deskew.sv
// CSI-2 lane deskew: per-lane FIFOs absorb start skew and emit one merged word per cycle.
// Raises a re-search request on skew violation, lane dropout or FIFO overflow.
module mipi_lane_deskew #(
  parameter int LANES      = 2,
  parameter int SKEW_DEPTH = 4
) (
  input  logic                 I_CLK,
  input  logic                 I_Rst,
  input  logic [8*LANES-1:0]   I_Lane_Data,
  input  logic [LANES-1:0]     I_Lane_Vaild,
  input  logic                 I_Packet_done,
  output logic [8*LANES-1:0]   O_Lane_Alignment_Data,
  output logic                 O_Lane_Alignment_Vaild,
  output logic                 O_ReSearch_Offset_Lane,
  output logic                 O_Skew_Err
);

  localparam int DEPTH = SKEW_DEPTH + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [3:0]    SKEW_MAX = 4'(SKEW_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM,
    S_RESYNC
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LANES-1:0]   r_seen;
  logic [3:0]         r_skew_cnt;
  logic [LANES-1:0]   w_empty;
  logic [LANES-1:0]   w_full;
  logic [LANES-1:0]   w_wr;
  logic [8*LANES-1:0] w_rd_data;
  logic [8*LANES-1:0] r_pipe_data;
  logic               r_pipe_vld;
  logic               w_pop;
  logic               w_done;
  logic               w_wr_en;
  logic               w_ovf;
  logic               w_err;
  logic               w_flush;

  assign w_done  = I_Packet_done && (r_state != S_RESYNC);
  assign w_wr_en = (r_state != S_RESYNC);
  assign w_pop   = (r_state == S_STREAM) && (&(~w_empty));
  // A pop frees a slot in every lane, so a full lane may still accept a byte.
  assign w_ovf   = w_wr_en && (|(I_Lane_Vaild & w_full)) && !w_pop;

  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (&I_Lane_Vaild) begin
          w_next = S_STREAM;
        end else if (|I_Lane_Vaild) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (&(r_seen | I_Lane_Vaild)) begin
          w_next = S_STREAM;
        end else if (r_skew_cnt >= SKEW_MAX) begin
          w_next = S_RESYNC;
        end
      end
      S_STREAM: begin
        if (&w_empty) begin
          w_next = S_IDLE;
        end else if (|w_empty) begin
          w_next = S_RESYNC;
        end
      end
      S_RESYNC: begin
        if (~|I_Lane_Vaild) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_ovf) begin
      w_next = S_RESYNC;
    end
    if (w_done) begin
      w_next = S_IDLE;
    end
  end

  always_comb begin
    w_err   = (w_next == S_RESYNC) && (r_state != S_RESYNC);
    w_flush = w_done || w_err;
    w_wr    = '0;
    if (w_wr_en && !w_flush) begin
      w_wr = I_Lane_Vaild & (~w_full | {LANES{w_pop}});
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      r_seen     <= '0;
      r_skew_cnt <= '0;
    end else if (w_next == S_WAIT) begin
      r_seen     <= r_seen | I_Lane_Vaild;
      r_skew_cnt <= (r_state == S_WAIT) ? r_skew_cnt + 4'd1 : 4'd1;
    end else begin
      r_seen     <= '0;
      r_skew_cnt <= '0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge I_CLK) begin
      if (w_wr[k]) begin
        r_mem[r_wp] <= I_Lane_Data[8*k +: 8];
      end
    end

    always_ff @(posedge I_CLK) begin
      if (I_Rst || w_flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_wr[k]) begin
          r_wp <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
        end
        if (w_pop) begin
          r_rp <= (r_rp == LAST) ? '0 : r_rp + 1'b1;
        end
        r_cnt <= r_cnt + CW'(w_wr[k]) - CW'(w_pop);
      end
    end

    assign w_empty[k]          = (r_cnt == '0);
    assign w_full[k]           = (r_cnt == FULL);
    assign w_rd_data[8*k +: 8] = r_mem[r_rp];
  end

  // Popped word passes a staging register so latency is uniform regardless of skew.
  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      r_pipe_vld             <= 1'b0;
      r_pipe_data            <= '0;
      O_Lane_Alignment_Vaild <= 1'b0;
      O_Lane_Alignment_Data  <= '0;
      O_ReSearch_Offset_Lane <= 1'b0;
      O_Skew_Err             <= 1'b0;
    end else begin
      r_pipe_vld <= w_pop && !w_flush;
      if (w_pop && !w_flush) begin
        r_pipe_data <= w_rd_data;
      end
      O_Lane_Alignment_Vaild <= r_pipe_vld && !w_done;
      if (r_pipe_vld && !w_done) begin
        O_Lane_Alignment_Data <= r_pipe_data;
      end
      O_ReSearch_Offset_Lane <= w_err;
      O_Skew_Err             <= w_err;
    end
  end

endmodule

// File: doc/mipi_lane_deskew.md
Name: mipi_lane_deskew

Overview:
- Parametrised successor to the fixed 2-lane lane aligner in the MIPI CSI-2 receive path.
- Sits between the per-lane byte aligners and the packet unpacker, in the byte-clock domain.
- Takes LANES byte-aligned streams with independent start times. Absorbs lane-to-lane skew up to SKEW_DEPTH byte clocks using per-lane FIFOs, then emits one merged 8*LANES-bit word per cycle.
- Detects skew violations, lane dropout and overflow, and requests a byte re-search.

Parameters:
- LANES, 2, number of data lanes; legal values 1, 2, 4.
- SKEW_DEPTH, 4, maximum tolerated skew between the earliest and latest lane start, in byte clocks; range 1..15.

Ports:
- I_CLK  in  1  byte clock.
- I_Rst  in  1  synchronous reset, active-high.
- I_Lane_Data  in  8*LANES  byte from lane k on bits [8k+7:8k].
- I_Lane_Vaild  in  LANES  per-lane valid; held high for the whole burst.
- I_Packet_done  in  1  1-cycle pulse from the unpacker marking end of packet.
- O_Lane_Alignment_Data  out  8*LANES  merged word; lane k on bits [8k+7:8k].
- O_Lane_Alignment_Vaild  out  1  merged word valid.
- O_ReSearch_Offset_Lane  out  1  1-cycle pulse that requests the byte aligners to re-search.
- O_Skew_Err  out  1  1-cycle error pulse, for debug counters.

Behaviour:
- Clocking and reset: single clock; all outputs are registered. On I_Rst, the next edge clears all outputs to 0, empties all FIFOs, zeroes the skew counter and sets state to IDLE. This applies mid-burst as well.
- Lane FIFOs: one per lane, SKEW_DEPTH+2 entries deep. A lane writes its FIFO on every cycle its I_Lane_Vaild is high while the state is IDLE, WAIT_ALL or STREAM. The write pointer wraps modulo the depth.
- IDLE:
  - All FIFOs are empty.
  - When any I_Lane_Vaild is high, go to WAIT_ALL and load skew_cnt=1.
  - With LANES=1, go directly to STREAM.
- WAIT_ALL:
  - Track a seen[k] flag per lane (sticky).
  - When all seen flags are set, including lanes seen in the same cycle, go to STREAM.
  - Otherwise increment skew_cnt. If skew_cnt reaches SKEW_DEPTH with lanes still unseen, go to RESYNC.
- STREAM:
  - Each cycle all FIFOs are non-empty, pop all of them simultaneously and register the concatenation with O_Lane_Alignment_Vaild=1.
  - First merged word appears 2 cycles after the latest lane's first valid sample.
  - If all FIFOs are empty in the same cycle, the burst has ended: go to IDLE with valid=0.
  - If some FIFOs are empty and others are not (lane dropout or mismatch), go to RESYNC.
- Overflow: a write to a full FIFO in any state discards the byte and goes to RESYNC.
- RESYNC:
  - On the entry edge, pulse O_ReSearch_Offset_Lane and O_Skew_Err for exactly 1 cycle.
  - Flush all FIFOs and clear the seen flags.
  - Ignore input; stay in RESYNC until all I_Lane_Vaild are low, then go to IDLE.
- I_Packet_done:
  - In any state other than RESYNC: flush FIFOs, clear seen flags, go to IDLE, drive valid=0 next cycle. No ReSearch or Skew_Err pulse.
  - It takes priority over a skew or overflow error detected in the same cycle, so no error pulse is raised then.
  - While still in RESYNC: ignored.
- Output hold: O_Lane_Alignment_Data holds its last value when valid=0.
- Data ordering: byte i of lane k always pairs with byte i of every other lane. Skew is removed, never reordered.

Test Plan:
- LANES=2, both valids rise at cycle t, lane0 bytes 0x10,0x11,0x12, lane1 bytes 0x20,0x21,0x22.
  -> Data 16'h2010, 16'h2111, 16'h2212 at cycles t+2..t+4, valid high for exactly 3 cycles, no error pulses.
- LANES=2, SKEW_DEPTH=4, lane1 starts 3 cycles after lane0, same byte pattern.
  -> Identical 16'h2010.. sequence starting at t+5, no Skew_Err.
- LANES=2, SKEW_DEPTH=4, lane1 starts 5 cycles late.
  -> ReSearch and Skew_Err pulse 1 cycle each, no valid output.
  -> After both valids fall, a clean aligned burst is merged correctly.
- LANES=2, lane1 valid drops 2 cycles before lane0 valid.
  -> Partial empty in STREAM gives RESYNC pulse.
  -> Words emitted before the dropout are correct.
- LANES=4, skews 0,1,2,3, lane k bytes 0xk0 ascending.
  -> First word 32'h30201000 at latest-start+2, then 32'h31211101, and so on.
- I_Packet_done mid-STREAM, and separately I_Rst mid-STREAM.
  -> Valid=0 on the next cycle, FIFOs empty, no error pulse.
  -> A following burst merges with the nominal latency.
